mem_handshake_ctrl: RTL

- Sequences every RAM access requested by the microprogrammed control unit.
- Accepts the control unit's MOV/RW request plus MAR address and access size. Drives the RAM strobes for a programmable number of wait states, then returns MOC with a four-phase handshake.
- Detects misaligned halfword/word accesses; these are reported instead of reaching RAM.
- Sits between the control unit/MAR and the RAM module.

---
 rtl/sparc_mem_pkg.sv | 30 +++
 rtl/mem_handshake_ctrl_wait_counter.sv | 38 +++
 rtl/mem_handshake_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/sparc_mem_pkg.sv
// Shared encodings for the memory handshake controller: access sizes,
// controller state codes and the alignment rule applied to every request.
package sparc_mem_pkg;

    // Access size encodings as presented by the control unit (11 acts as word).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Controller state codes.
    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACCESS = 2'b01;
    localparam logic [1:0] S_DONE   = 2'b10;
    localparam logic [1:0] S_TRAP   = 2'b11;

    // A halfword must sit on an even address; a word (or reserved size)
    // must sit on a multiple of four. Bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a_lo);
        logic bad;
        if (sz == SZ_BYTE) begin
            bad = 1'b0;
        end else if (sz == SZ_HALF) begin
            bad = a_lo[0];
        end else begin
            bad = (a_lo != 2'b00);
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_handshake_ctrl_wait_counter.sv
// Loadable 4-bit down-counter that times the RAM strobe. It stops at zero
// and reports zero combinationally from its own register.
module mem_wait_counter
    import sparc_mem_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       en_i,
    output logic       zero_o
);

    logic [3:0] count_q;
    logic [3:0] count_d;

    // Load takes priority over counting; counting saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != 4'd0)) begin
            count_d = count_q - 4'd1;
        end
    end

    // Counter register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/mem_handshake_ctrl.sv
// Memory handshake controller: accepts a MOV/RW request from the control
// unit, latches the MAR address and size, strobes the RAM for WAIT_CYCLES
// cycles and answers with MOC using a four-phase handshake. Misaligned
// requests never reach the RAM and are answered with MOC plus a trap flag.
//
// Handshake: the control unit raises MOV and keeps it high; the controller
// raises MOC when the access (or trap) is complete and keeps it high until
// MOV is seen low, then drops MOC and returns to idle. Dropping MOV before
// MOC aborts the access. A new request needs MOV low for one sampled edge.
module mem_handshake_ctrl
    import sparc_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 9
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MOV,
    input  logic              RW,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    output logic              MOC,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [1:0]        ram_size,
    output logic              busy,
    output logic              misalign_trap
);

    // Counter reload value: the strobe lasts the load edge plus WAIT_CYCLES-1 more.
    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYCLES - 1);

    logic [1:0]        state_q, state_d;
    logic              moc_q, moc_d;
    logic              en_q, en_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              busy_q, busy_d;
    logic              trap_q, trap_d;

    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;

    // Upper MAR bits do not address this RAM.
    logic              unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W];

    mem_wait_counter u_wait_counter (
        .clk        (clk),
        .clr        (clr),
        .load_i     (cnt_load),
        .load_val_i (LOAD_VAL),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_d  = state_q;
        moc_d    = moc_q;
        en_d     = en_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        size_d   = size_q;
        trap_d   = trap_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (MOV) begin
                    addr_d = addr[ADDR_W-1:0];
                    rw_d   = RW;
                    size_d = size;
                    if (is_misaligned(size, addr[1:0])) begin
                        state_d = S_TRAP;
                        en_d    = 1'b0;
                    end else begin
                        state_d  = S_ACCESS;
                        en_d     = 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (!MOV) begin
                    // Abort: requester withdrew before completion.
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                end else if (cnt_zero) begin
                    state_d = S_DONE;
                    en_d    = 1'b0;
                    moc_d   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            S_DONE: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                end
            end
            S_TRAP: begin
                if (!MOV) begin
                    state_d = S_IDLE;
                    moc_d   = 1'b0;
                    trap_d  = 1'b0;
                end else begin
                    moc_d  = 1'b1;
                    trap_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                moc_d   = 1'b0;
                en_d    = 1'b0;
                trap_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            moc_q   <= 1'b0;
            en_q    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            size_q  <= 2'b00;
            busy_q  <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            moc_q   <= moc_d;
            en_q    <= en_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            busy_q  <= busy_d;
            trap_q  <= trap_d;
        end
    end

    assign MOC           = moc_q;
    assign ram_en        = en_q;
    assign ram_rw        = rw_q;
    assign ram_addr      = addr_q;
    assign ram_size      = size_q;
    assign busy          = busy_q;
    assign misalign_trap = trap_q;

endmodule
